stage2_id: RTL and testbench
============================

# stage2_id

Instruction-decode stage of the five-stage pipeline, directly downstream of instruction fetch. It decodes the fetched instruction, reads the 32x32 register file (written back from WB), resolves beq/bne in ID, detects load-use and branch-operand hazards, and drives fetch's branch-redirect and hold/flush controls. Its ID/EX pipeline register feeds the execute stage.

## Interface
- DATA_WIDTH, 32, datapath width
- clk  in  1  pipeline clock, rising edge
- rstb  in  1  asynchronous, active-low reset
- pc_plus4  in  32  PC+4 of instruction in IF/ID
- instr  in  32  instruction in IF/ID (all-zero = bubble)
- wb_we, wb_addr, wb_data  in  1/5/32  register-file write port from WB
- mem_reg_write, mem_rd  in  1/5  register-write flag and destination of instruction in MEM
- pc_src  out  1  1 = fetch takes branch target
- pc_plus4_plusimm16  out  32  branch target
- hold_pc, hold_if  out  1  freeze PC / freeze IF/ID register
- if_flush  out  1  zero the instruction entering IF/ID
- ex_rs_data, ex_rt_data, ex_imm  out  32  ID/EX operands, sign-extended immediate
- ex_rs, ex_rt, ex_rd  out  5  source regs; destination after RegDst select
- ex_alu_op  out  4  0 add, 1 sub, 2 and, 3 or, 4 slt
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1  ID/EX controls

## Operation
- Supported: R-type (op 0) funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2a slt; addi 0x08; lw 0x23; sw 0x2b; beq 0x04; bne 0x05. Any other opcode/funct, or instr = 0, decodes as bubble (all controls 0).
- Destination: rd for R-type, rt for addi/lw; sw/beq/bne write nothing.
- imm = sign-extended instr[15:0]; target = pc_plus4 + (imm << 2), 32-bit modulo, always driven.
- Register file: $0 reads 0 and ignores writes; write at rising edge when wb_we; same-cycle write-through (wb_we && wb_addr == source && source != 0 returns wb_data).
- Uses-rt: R-type, sw, beq, bne. Uses-rs: every non-bubble.
- Load-use stall: ex_mem_read && ex_rd != 0 && ex_rd matches a used source.
- Branch stall (beq/bne only): (ex_reg_write && ex_rd != 0 && match) or (mem_reg_write && mem_rd != 0 && match). No branch forwarding.
- Stall: hold_pc = hold_if = 1, pc_src = 0, if_flush = 0; ID/EX loads a bubble.
- Branch resolution (no stall): compare rs vs rt operands; taken when beq & equal or bne & unequal. Taken: pc_src = 1, if_flush = 1, holds 0.
- Branches always enter ID/EX as a bubble.
- Priority: stall over branch-taken. Bubble instr never stalls or branches.

## Timing
- Decode, register read, hazard logic, pc_src, target, hold_*, if_flush: combinational within the cycle.
- ID/EX register updates every rising edge (no hold input); instruction in IF/ID in cycle n appears on ex_* in cycle n+1.
- Taken branch: one-cycle penalty. The flushed slot enters IF/ID as 0; the target is fetched the next cycle.
- Load-use: exactly one stall cycle. Branch after ALU op: one or two stall cycles until the producer leaves MEM. WB write-through covers the WB stage.
- Reset (any time, async): all ID/EX outputs 0 and all 32 registers 0. With instr = 0: pc_src = 0, hold_pc = hold_if = 0, if_flush = 0, target = pc_plus4.
- Reset release mid-cycle: first ID/EX capture at the next rising edge.

## Test plan
- After reset, WB-write $8 = 0x0000_0005 then decode add $9,$8,$8 -> ex_rs_data = ex_rt_data = 5, ex_rd = 9, ex_alu_op = 0, ex_reg_write = 1.
- Write-through: wb_we = 1, wb_addr = 3, wb_data = 0xDEAD_BEEF while decoding or $4,$3,$0 -> ex_rs_data = 0xDEAD_BEEF next edge; write to $0 -> reads 0.
- lw $2,0($1) then add $3,$2,$2 -> one cycle with hold_pc = hold_if = 1 and bubble in ID/EX, then add issues. Same with lw $0 -> no stall.
- beq $1,$1,+4 at pc_plus4 = 0x0040_0024 -> pc_src = 1, if_flush = 1, target = 0x0040_0034, bubble in ID/EX. bne on equal -> pc_src = 0.
- addi $5,$0,1 then beq $5,$0,-1 -> two stall cycles (producer in EX, then MEM), then not taken. Target = pc_plus4 - 4.
- Assert rstb low mid-stream -> all ex_* 0 immediately, registers read 0 after release. Illegal opcode 0x3F -> full bubble.

Source files
------------

// File: rtl/stage2_id.sv
// Instruction-decode stage: decodes IF/ID, reads the register file, resolves
// beq/bne, detects load-use and branch-operand hazards and loads the ID/EX register.
module stage2_id #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic [31:0]           instr,
  input  logic                  wb_we,
  input  logic [4:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  mem_reg_write,
  input  logic [4:0]            mem_rd,
  output logic                  pc_src,
  output logic [DATA_WIDTH-1:0] pc_plus4_plusimm16,
  output logic                  hold_pc,
  output logic                  hold_if,
  output logic                  if_flush,
  output logic [DATA_WIDTH-1:0] ex_rs_data,
  output logic [DATA_WIDTH-1:0] ex_rt_data,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [4:0]            ex_rs,
  output logic [4:0]            ex_rt,
  output logic [4:0]            ex_rd,
  output logic [3:0]            ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write,
  output logic                  ex_mem_to_reg
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2a;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [3:0]            alu_op;
    logic                  alu_src;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
  } idex_t;

  function automatic logic signed [DATA_WIDTH-1:0] sext16(input logic [15:0] v);
    return {{(DATA_WIDTH-16){v[15]}}, v};
  endfunction

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic signed [DATA_WIDTH-1:0] imm_p0;
  logic [DATA_WIDTH-1:0] rs_val, rt_val;
  logic [DATA_WIDTH-1:0] regs [32];

  logic is_r, is_addi, is_lw, is_sw, is_beq, is_bne;
  logic is_branch, valid, uses_rt;
  logic ex_hit, mem_hit, load_use, br_stall, stall, taken;
  logic [3:0] alu_op_p0;
  idex_t idex_p0, idex_p1;

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm_p0 = sext16(instr[15:0]);

  assign pc_plus4_plusimm16 = pc_plus4 + $unsigned(imm_p0 <<< 2);

  // Register file: $0 is never written, so it always reads back zero
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign rs_val = (rs == 5'd0) ? '0 : (wb_we && wb_addr == rs) ? wb_data : regs[rs];
  assign rt_val = (rt == 5'd0) ? '0 : (wb_we && wb_addr == rt) ? wb_data : regs[rt];

  always_comb begin
    is_r      = 1'b0;
    is_addi   = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    alu_op_p0 = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        is_r = 1'b1;
        case (funct)
          F_ADD:   alu_op_p0 = ALU_ADD;
          F_SUB:   alu_op_p0 = ALU_SUB;
          F_AND:   alu_op_p0 = ALU_AND;
          F_OR:    alu_op_p0 = ALU_OR;
          F_SLT:   alu_op_p0 = ALU_SLT;
          default: is_r = 1'b0;
        endcase
      end
      OP_ADDI: is_addi = 1'b1;
      OP_LW:   is_lw   = 1'b1;
      OP_SW:   is_sw   = 1'b1;
      OP_BEQ:  is_beq  = 1'b1;
      OP_BNE:  is_bne  = 1'b1;
      default: ;
    endcase
  end

  assign is_branch = is_beq | is_bne;
  assign valid     = is_r | is_addi | is_lw | is_sw | is_branch;
  assign uses_rt   = is_r | is_sw | is_branch;

  // Hazards against the producers currently in EX and MEM
  assign ex_hit   = (idex_p1.rd != 5'd0) && ((idex_p1.rd == rs) || (uses_rt && idex_p1.rd == rt));
  assign mem_hit  = (mem_rd != 5'd0) && ((mem_rd == rs) || (mem_rd == rt));
  assign load_use = valid && idex_p1.mem_read && ex_hit;
  assign br_stall = is_branch && ((idex_p1.reg_write && ex_hit) || (mem_reg_write && mem_hit));
  assign stall    = load_use | br_stall;

  assign taken    = !stall && ((is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val));
  assign pc_src   = taken;
  assign if_flush = taken;
  assign hold_pc  = stall;
  assign hold_if  = stall;

  // Stalls, branches and undecodable words all enter ID/EX as an all-zero bubble
  always_comb begin
    idex_p0 = '0;
    if (valid && !stall && !is_branch) begin
      idex_p0.rs_data    = rs_val;
      idex_p0.rt_data    = rt_val;
      idex_p0.imm        = $unsigned(imm_p0);
      idex_p0.rs         = rs;
      idex_p0.rt         = rt;
      idex_p0.rd         = is_r ? rd : ((is_addi | is_lw) ? rt : 5'd0);
      idex_p0.alu_op     = is_r ? alu_op_p0 : ALU_ADD;
      idex_p0.alu_src    = is_addi | is_lw | is_sw;
      idex_p0.mem_read   = is_lw;
      idex_p0.mem_write  = is_sw;
      idex_p0.reg_write  = is_r | is_addi | is_lw;
      idex_p0.mem_to_reg = is_lw;
    end
  end

  // ---- ID / EX boundary ----
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) idex_p1 <= '0;
    else       idex_p1 <= idex_p0;
  end

  assign ex_rs_data    = idex_p1.rs_data;
  assign ex_rt_data    = idex_p1.rt_data;
  assign ex_imm        = idex_p1.imm;
  assign ex_rs         = idex_p1.rs;
  assign ex_rt         = idex_p1.rt;
  assign ex_rd         = idex_p1.rd;
  assign ex_alu_op     = idex_p1.alu_op;
  assign ex_alu_src    = idex_p1.alu_src;
  assign ex_mem_read   = idex_p1.mem_read;
  assign ex_mem_write  = idex_p1.mem_write;
  assign ex_reg_write  = idex_p1.reg_write;
  assign ex_mem_to_reg = idex_p1.mem_to_reg;

endmodule

// File: tb/tb_stage2_id.sv
// Bench for stage2_id: emulates IF, EX, MEM and WB around the decode stage and
// checks every cycle against an instruction-level reference model.
module tb_stage2_id;

  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] pc_plus4, instr, wb_data;
  logic        wb_we, mem_reg_write;
  logic [4:0]  wb_addr, mem_rd;
  logic        pc_src, hold_pc, hold_if, if_flush;
  logic [31:0] pc_plus4_plusimm16, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;

  always #5 clk = ~clk;

  stage2_id #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rstb(rstb), .pc_plus4(pc_plus4), .instr(instr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .pc_src(pc_src), .pc_plus4_plusimm16(pc_plus4_plusimm16),
    .hold_pc(hold_pc), .hold_if(hold_if), .if_flush(if_flush),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  typedef struct packed {
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  alu_op;
    logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg;
  } idex_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  idex_t       ex_m;
  wr_t         exmem_m, memwb_m;
  logic [31:0] mreg [32];
  int          n_tests, n_fail;
  logic        last_stall, last_taken;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] s, t, d);
    return {6'h00, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s, t,
                                        input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic logic [31:0] rd_ref(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (memwb_m.we && memwb_m.rd == a) return memwb_m.data;
    return mreg[a];
  endfunction

  // Result the bench's EX/MEM would write back; loads return a synthetic memory word
  function automatic logic [31:0] alu_ref(input idex_t e);
    logic [31:0] b;
    b = e.alu_src ? e.imm : e.rt_data;
    if (e.mem_to_reg) return 32'hC0DE_0000 ^ (e.rs_data + e.imm);
    case (e.alu_op)
      4'd1:    return e.rs_data - b;
      4'd2:    return e.rs_data & b;
      4'd3:    return e.rs_data | b;
      4'd4:    return ($signed(e.rs_data) < $signed(b)) ? 32'd1 : 32'd0;
      default: return e.rs_data + b;
    endcase
  endfunction

  // kind: 0 bubble, 1 R-type, 2 addi, 3 lw, 4 sw, 5 beq, 6 bne
  task automatic model_id(input logic [31:0] ins, input logic [31:0] pc4, output idex_t nxt,
                          output logic stall, output logic taken, output logic [31:0] tgt);
    int          kind;
    logic [3:0]  aop;
    logic [4:0]  s, t, d;
    logic [31:0] imm;
    logic        br, use_t, hit_ex, hit_mem, eq;
    s = ins[25:21]; t = ins[20:16]; d = ins[15:11];
    imm = {{16{ins[15]}}, ins[15:0]};
    kind = 0; aop = 4'd0;
    case (ins[31:26])
      6'h00: case (ins[5:0])
               6'h20: begin kind = 1; aop = 4'd0; end
               6'h22: begin kind = 1; aop = 4'd1; end
               6'h24: begin kind = 1; aop = 4'd2; end
               6'h25: begin kind = 1; aop = 4'd3; end
               6'h2a: begin kind = 1; aop = 4'd4; end
               default: kind = 0;
             endcase
      6'h08: kind = 2;
      6'h23: kind = 3;
      6'h2b: kind = 4;
      6'h04: kind = 5;
      6'h05: kind = 6;
      default: kind = 0;
    endcase
    tgt     = pc4 + imm * 32'd4;
    br      = (kind == 5) || (kind == 6);
    use_t   = (kind == 1) || (kind == 4) || br;
    hit_ex  = (ex_m.rd != 0) && (ex_m.rd == s || (use_t && ex_m.rd == t));
    hit_mem = exmem_m.we && (exmem_m.rd != 0) && (exmem_m.rd == s || exmem_m.rd == t);
    stall   = (kind != 0) && ((ex_m.mem_read && hit_ex) ||
                              (br && ((ex_m.reg_write && hit_ex) || hit_mem)));
    eq      = (rd_ref(s) == rd_ref(t));
    taken   = !stall && ((kind == 5 && eq) || (kind == 6 && !eq));
    nxt     = '0;
    if (!stall && kind >= 1 && kind <= 4) begin
      nxt.rs_data    = rd_ref(s);
      nxt.rt_data    = rd_ref(t);
      nxt.imm        = imm;
      nxt.rs         = s;
      nxt.rt         = t;
      nxt.rd         = (kind == 1) ? d : (kind == 4) ? 5'd0 : t;
      nxt.alu_op     = (kind == 1) ? aop : 4'd0;
      nxt.alu_src    = (kind != 1);
      nxt.mem_read   = (kind == 3);
      nxt.mem_write  = (kind == 4);
      nxt.reg_write  = (kind != 4);
      nxt.mem_to_reg = (kind == 3);
    end
  endtask

  task automatic model_clear();
    ex_m = '0; exmem_m = '0; memwb_m = '0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    last_stall = 1'b0; last_taken = 1'b0;
  endtask

  task automatic drive();
    mem_reg_write = exmem_m.we; mem_rd = exmem_m.rd;
    wb_we = memwb_m.we; wb_addr = memwb_m.rd; wb_data = memwb_m.data;
  endtask

  task automatic check_ex();
    chk("ex_rs_data", ex_rs_data, ex_m.rs_data);
    chk("ex_rt_data", ex_rt_data, ex_m.rt_data);
    chk("ex_imm", ex_imm, ex_m.imm);
    chk("ex_rs", 32'(ex_rs), 32'(ex_m.rs));
    chk("ex_rt", 32'(ex_rt), 32'(ex_m.rt));
    chk("ex_rd", 32'(ex_rd), 32'(ex_m.rd));
    chk("ex_alu_op", 32'(ex_alu_op), 32'(ex_m.alu_op));
    chk("ex_alu_src", 32'(ex_alu_src), 32'(ex_m.alu_src));
    chk("ex_mem_read", 32'(ex_mem_read), 32'(ex_m.mem_read));
    chk("ex_mem_write", 32'(ex_mem_write), 32'(ex_m.mem_write));
    chk("ex_reg_write", 32'(ex_reg_write), 32'(ex_m.reg_write));
    chk("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(ex_m.mem_to_reg));
  endtask

  // One pipeline cycle: check ID outputs mid-cycle, clock, advance the model, check ID/EX
  task automatic tick();
    idex_t       nxt;
    logic        st, tk;
    logic [31:0] tg;
    drive();
    #2;
    model_id(instr, pc_plus4, nxt, st, tk, tg);
    chk("pc_src", 32'(pc_src), 32'(tk));
    chk("if_flush", 32'(if_flush), 32'(tk));
    chk("hold_pc", 32'(hold_pc), 32'(st));
    chk("hold_if", 32'(hold_if), 32'(st));
    chk("target", pc_plus4_plusimm16, tg);
    last_stall = st; last_taken = tk;
    @(posedge clk);
    #1;
    if (memwb_m.we && memwb_m.rd != 5'd0) mreg[memwb_m.rd] = memwb_m.data;
    memwb_m = exmem_m;
    exmem_m = '{ex_m.reg_write, ex_m.rd, alu_ref(ex_m)};
    ex_m    = nxt;
    check_ex();
  endtask

  task automatic drain(input int n);
    instr = 32'd0;
    repeat (n) tick();
  endtask

  // Present one instruction and hold it while the stage stalls; returns the stall count
  task automatic issue(input logic [31:0] ins, output int stalls);
    logic done;
    instr = ins; stalls = 0; done = 1'b0;
    for (int k = 0; k < 5 && !done; k++) begin
      tick();
      if (last_stall) stalls++;
      else done = 1'b1;
    end
    if (!done) chk("issue_timeout", 32'(stalls), 32'd4);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rstb = 1'b0;
    #1;
    model_clear();
    check_ex();
    instr = 32'd0;
    drive();
    #1;
    chk("rst_pc_src", 32'(pc_src), 32'd0);
    chk("rst_hold", 32'({hold_pc, hold_if, if_flush}), 32'd0);
    chk("rst_target", pc_plus4_plusimm16, pc_plus4);
    @(negedge clk);
    #2;
    rstb = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  s, t, d;
    logic [15:0] im;
    logic [5:0]  fn [5];
    fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    s = 5'($urandom_range(0, 7)); t = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
    im = 16'($urandom);
    case ($urandom_range(0, 11))
      0, 1, 2, 3: return enc_r(fn[$urandom_range(0, 4)], s, t, d);
      4:  return enc_i(6'h08, s, t, im);
      5:  return enc_i(6'h23, s, t, im);
      6:  return enc_i(6'h2b, s, t, im);
      7:  return enc_i(6'h04, s, t, im);
      8:  return enc_i(6'h05, s, t, im);
      9:  return {6'h3F, 26'($urandom)};
      10: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    n_tests = 0; n_fail = 0;
    rstb = 1'b0; instr = 32'd0; pc_plus4 = 32'h0040_0000;
    model_clear();
    drive();
    #8;
    check_ex();
    chk("init_pc_src", 32'(pc_src), 32'd0);
    chk("init_hold", 32'({hold_pc, hold_if, if_flush}), 32'd0);
    chk("init_target", pc_plus4_plusimm16, 32'h0040_0000);
    #3;
    rstb = 1'b1;
    drain(2);

    // Plain register read after a WB write
    memwb_m = '{1'b1, 5'd8, 32'd5};
    issue(enc_r(6'h20, 5'd8, 5'd8, 5'd9), st);
    chk("add_rs", ex_rs_data, 32'd5);
    chk("add_rt", ex_rt_data, 32'd5);
    chk("add_rd", 32'(ex_rd), 32'd9);
    chk("add_op", 32'(ex_alu_op), 32'd0);
    chk("add_we", 32'(ex_reg_write), 32'd1);
    drain(3);

    // Same-cycle WB write-through, and $0 never returns written data
    memwb_m = '{1'b1, 5'd3, 32'hDEAD_BEEF};
    issue(enc_r(6'h25, 5'd3, 5'd0, 5'd4), st);
    chk("wt_rs", ex_rs_data, 32'hDEAD_BEEF);
    drain(3);
    memwb_m = '{1'b1, 5'd0, 32'h1234_5678};
    issue(enc_r(6'h20, 5'd0, 5'd0, 5'd6), st);
    chk("r0_rs", ex_rs_data, 32'd0);
    drain(3);

    // Load-use: one stall; a load to $0 never stalls
    issue(enc_i(6'h23, 5'd1, 5'd2, 16'd0), st);
    issue(enc_r(6'h20, 5'd2, 5'd2, 5'd3), st);
    chk("lu_stalls", 32'(st), 32'd1);
    chk("lu_issue_rd", 32'(ex_rd), 32'd3);
    drain(3);
    issue(enc_i(6'h23, 5'd1, 5'd0, 16'd0), st);
    issue(enc_r(6'h20, 5'd0, 5'd0, 5'd3), st);
    chk("lu0_stalls", 32'(st), 32'd0);
    drain(3);

    // Taken beq, then bne on equal operands
    pc_plus4 = 32'h0040_0024;
    instr = enc_i(6'h04, 5'd1, 5'd1, 16'd4);
    drive();
    #1;
    chk("beq_pc_src", 32'(pc_src), 32'd1);
    chk("beq_flush", 32'(if_flush), 32'd1);
    chk("beq_target", pc_plus4_plusimm16, 32'h0040_0034);
    tick();
    chk("beq_bubble", 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'd0);
    drain(1);
    instr = enc_i(6'h05, 5'd1, 5'd1, 16'd4);
    drive();
    #1;
    chk("bne_eq_pc_src", 32'(pc_src), 32'd0);
    tick();
    drain(2);

    // Branch on a fresh ALU result: stalls while the producer sits in EX and MEM
    issue(enc_i(6'h08, 5'd0, 5'd5, 16'd1), st);
    pc_plus4 = 32'h0040_0100;
    issue(enc_i(6'h04, 5'd5, 5'd0, 16'hFFFF), st);
    chk("br_stalls", 32'(st), 32'd2);
    chk("br_target", pc_plus4_plusimm16, 32'h0040_00FC);
    chk("br_not_taken", 32'(pc_src), 32'd0);
    drain(3);

    // Illegal opcode decodes as a full bubble
    issue({6'h3F, 5'd1, 5'd2, 16'h7FFF}, st);
    chk("ill_ctrl", 32'({ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg}), 32'd0);
    chk("ill_imm", ex_imm, 32'd0);

    // Asynchronous reset mid-stream clears the register file
    memwb_m = '{1'b1, 5'd8, 32'h0000_0077};
    drain(1);
    do_reset();
    issue(enc_r(6'h20, 5'd8, 5'd8, 5'd9), st);
    chk("rst_reg_rs", ex_rs_data, 32'd0);
    drain(2);

    // Randomized stream; the bench acts as IF (hold and flush) and EX/MEM/WB
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      if (!last_stall) begin
        instr = last_taken ? 32'd0 : rand_instr();
        pc_plus4 = $urandom & 32'hFFFF_FFFC;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
